// File: rtl/run_ctrl_pkg.sv
// Shared encodings for the core run/step controller: command opcodes,
// FSM states and stop-reason codes.
package run_ctrl_pkg;

    localparam logic [1:0] OP_RUN_N    = 2'd0;
    localparam logic [1:0] OP_STEP     = 2'd1;
    localparam logic [1:0] OP_RUN_FREE = 2'd2;
    localparam logic [1:0] OP_HALT     = 2'd3;

    localparam logic [1:0] SR_COUNT = 2'd0;
    localparam logic [1:0] SR_HALT  = 2'd1;
    localparam logic [1:0] SR_CORE  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN_N    = 2'd1,
        ST_RUN_FREE = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; synchronous
// active-low clear.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         i_clr_n,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!i_clr_n) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/core_run_ctrl.sv
// Run/step controller: gates the core clock-enable for N cycles, one step
// or free-running, and reports why each run ended.
module core_run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int TOT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             core_stop,
    output logic             core_en,
    output logic             busy,
    output logic             done,
    output logic [1:0]       stop_reason,
    output logic             cmd_err,
    output logic [CNT_W-1:0] cycles_left,
    output logic [TOT_W-1:0] cycles_total
);

    state_t           r_state;
    logic             r_core_en;
    logic             r_busy;
    logic             r_done;
    logic [1:0]       r_stop_reason;
    logic             r_cmd_err;
    logic [CNT_W-1:0] r_cycles_left;

    state_t           w_state_nxt;
    logic [1:0]       w_reason_nxt;
    logic             w_err_nxt;
    logic [CNT_W-1:0] w_left_nxt;
    logic             w_accept;
    logic             w_running;
    logic             w_run_nxt;

    assign w_running = (r_state == ST_RUN_N) || (r_state == ST_RUN_FREE);
    assign w_accept  = cmd_valid && cmd_ready;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_reason_nxt = r_stop_reason;
        w_err_nxt    = 1'b0;
        w_left_nxt   = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    unique case (cmd_op)
                        OP_RUN_N: begin
                            if (cmd_count == '0) begin
                                w_state_nxt  = ST_DONE;
                                w_reason_nxt = SR_COUNT;
                            end else begin
                                w_state_nxt = ST_RUN_N;
                                w_left_nxt  = cmd_count;
                            end
                        end
                        OP_STEP: begin
                            w_state_nxt = ST_RUN_N;
                            w_left_nxt  = CNT_W'(1);
                        end
                        OP_RUN_FREE: w_state_nxt = ST_RUN_FREE;
                        default:     w_state_nxt = ST_IDLE;
                    endcase
                end
            end
            ST_RUN_N, ST_RUN_FREE: begin
                // Priority: HALT command, then core halt, then count exhausted.
                w_err_nxt = w_accept && (cmd_op != OP_HALT);
                if (w_accept && (cmd_op == OP_HALT)) begin
                    w_state_nxt  = ST_DONE;
                    w_reason_nxt = SR_HALT;
                end else if (core_stop) begin
                    w_state_nxt  = ST_DONE;
                    w_reason_nxt = SR_CORE;
                end else if ((r_state == ST_RUN_N) && (r_cycles_left == CNT_W'(1))) begin
                    w_state_nxt  = ST_DONE;
                    w_reason_nxt = SR_COUNT;
                end else if (r_state == ST_RUN_N) begin
                    w_left_nxt = r_cycles_left - 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_run_nxt = (w_state_nxt == ST_RUN_N) || (w_state_nxt == ST_RUN_FREE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_core_en     <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_stop_reason <= SR_COUNT;
            r_cmd_err     <= 1'b0;
            r_cycles_left <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_core_en     <= w_run_nxt;
            r_busy        <= w_run_nxt;
            r_done        <= (w_state_nxt == ST_DONE);
            r_stop_reason <= w_reason_nxt;
            r_cmd_err     <= w_err_nxt;
            r_cycles_left <= w_left_nxt;
        end
    end

    sat_counter #(
        .W (TOT_W)
    ) u_total (
        .clk     (clk),
        .i_clr_n (rst_n),
        .i_inc   (r_core_en),
        .o_count (cycles_total)
    );

    // DONE holds off new commands for its single cycle.
    assign cmd_ready   = (r_state != ST_DONE);
    assign core_en     = r_core_en;
    assign busy        = r_busy;
    assign done        = r_done;
    assign stop_reason = r_stop_reason;
    assign cmd_err     = r_cmd_err;
    assign cycles_left = r_cycles_left;

    // w_running documents the run states for readers; keep it observable.
    logic w_unused;
    assign w_unused = w_running;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Self-checking bench for core_run_ctrl: a transaction-level model predicts
// run length, stop reason and executed-cycle totals for each command.
module tb_core_run_ctrl;
    import run_ctrl_pkg::*;

    localparam int CNT_W = 16;
    localparam int TOT_W = 32;
    localparam int SAT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic [1:0]       cmd_op = 2'd0;
    logic [CNT_W-1:0] cmd_count = '0;
    logic             core_stop = 1'b0;

    logic             cmd_ready, core_en, busy, done, cmd_err;
    logic [1:0]       stop_reason;
    logic [CNT_W-1:0] cycles_left;
    logic [TOT_W-1:0] cycles_total;

    logic             s_cmd_ready, s_core_en, s_busy, s_done, s_cmd_err;
    logic [1:0]       s_stop_reason;
    logic [CNT_W-1:0] s_cycles_left;
    logic [SAT_W-1:0] s_cycles_total;

    core_run_ctrl #(.CNT_W(CNT_W), .TOT_W(TOT_W)) u_dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_count(cmd_count), .core_stop(core_stop),
        .core_en(core_en), .busy(busy), .done(done), .stop_reason(stop_reason),
        .cmd_err(cmd_err), .cycles_left(cycles_left), .cycles_total(cycles_total)
    );

    // Narrow-total twin driven identically, to exercise saturation.
    core_run_ctrl #(.CNT_W(CNT_W), .TOT_W(SAT_W)) u_sat (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(s_cmd_ready),
        .cmd_op(cmd_op), .cmd_count(cmd_count), .core_stop(core_stop),
        .core_en(s_core_en), .busy(s_busy), .done(s_done), .stop_reason(s_stop_reason),
        .cmd_err(s_cmd_err), .cycles_left(s_cycles_left), .cycles_total(s_cycles_total)
    );

    always #5 clk = ~clk;

    int     n_tests = 0;
    int     n_fail  = 0;
    longint exp_total = 0;
    logic [1:0] last_reason = SR_COUNT;

    function automatic logic [TOT_W+SAT_W-1:0] exp_totals();
        logic [TOT_W-1:0] t32;
        logic [SAT_W-1:0] t4;
        t32 = (exp_total > longint'(32'hFFFF_FFFF)) ? '1 : TOT_W'(exp_total);
        t4  = (exp_total > 15) ? '1 : SAT_W'(exp_total);
        return {t32, t4};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One command from acceptance to the IDLE cycle after DONE. Positions are
    // 1-based core_en cycles; 0 means "not used".
    task automatic do_run(input logic [1:0] op, input int count, input int stop_at,
                          input int halt_at, input int step_at_in);
        int n, len, step_at;
        logic [1:0] reason;
        logic [4:0] e_st;
        logic [CNT_W-1:0] e_left;
        n   = (op == OP_STEP) ? 1 : (op == OP_RUN_FREE) ? (1 << 30) : count;
        len = n;
        if (halt_at != 0 && halt_at < len) len = halt_at;
        if (stop_at != 0 && stop_at < len) len = stop_at;
        reason = (halt_at != 0 && halt_at == len) ? SR_HALT :
                 (stop_at != 0 && stop_at == len) ? SR_CORE : SR_COUNT;
        step_at = (step_at_in < len) ? step_at_in : 0;

        n_tests++;
        if ({cmd_ready, s_cmd_ready} !== 2'b11) begin
            n_fail++;
            $display("FAIL ready_before_cmd: got %b want 11", {cmd_ready, s_cmd_ready});
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_count = CNT_W'(count);
        tick();
        cmd_valid = 1'b0;
        cmd_count = CNT_W'($urandom);

        for (int i = 1; i <= len; i++) begin
            e_left = (op == OP_RUN_FREE) ? '0 : CNT_W'(n - i + 1);
            e_st   = {1'b1, 1'b1, 1'b0, 1'(step_at != 0 && i == step_at + 1), 1'b1};
            n_tests++;
            if ({core_en, busy, done, cmd_err, cmd_ready} !== e_st ||
                {s_core_en, s_busy, s_done, s_cmd_err, s_cmd_ready} !== e_st) begin
                n_fail++;
                $display("FAIL run_status cyc%0d: got %b/%b want %b", i,
                         {core_en, busy, done, cmd_err, cmd_ready},
                         {s_core_en, s_busy, s_done, s_cmd_err, s_cmd_ready}, e_st);
            end
            n_tests++;
            if (cycles_left !== e_left || s_cycles_left !== e_left) begin
                n_fail++;
                $display("FAIL cycles_left cyc%0d: got %0d/%0d want %0d", i,
                         cycles_left, s_cycles_left, e_left);
            end
            n_tests++;
            if ({cycles_total, s_cycles_total} !== exp_totals()) begin
                n_fail++;
                $display("FAIL total_run cyc%0d: got %0d/%0d want %h", i,
                         cycles_total, s_cycles_total, exp_totals());
            end
            core_stop = (i == stop_at);
            if (i == halt_at) begin
                cmd_valid = 1'b1;
                cmd_op    = OP_HALT;
            end else if (i == step_at) begin
                cmd_valid = 1'b1;
                cmd_op    = 2'($urandom_range(0, 2));
                cmd_count = CNT_W'($urandom_range(0, 50));
            end
            tick();
            exp_total++;
            cmd_valid = 1'b0;
            core_stop = 1'b0;
        end

        // DONE cycle; try to sneak in a command and a stray core_stop.
        n_tests++;
        if ({core_en, busy, done, cmd_err, cmd_ready} !== 5'b00100 ||
            {s_core_en, s_busy, s_done, s_cmd_err, s_cmd_ready} !== 5'b00100) begin
            n_fail++;
            $display("FAIL done_status: got %b/%b want 00100",
                     {core_en, busy, done, cmd_err, cmd_ready},
                     {s_core_en, s_busy, s_done, s_cmd_err, s_cmd_ready});
        end
        n_tests++;
        if ({stop_reason, s_stop_reason} !== {reason, reason} ||
            {cycles_left, s_cycles_left} !== '0) begin
            n_fail++;
            $display("FAIL done_reason: got %0d/%0d left %0d want %0d left 0",
                     stop_reason, s_stop_reason, cycles_left, reason);
        end
        n_tests++;
        if ({cycles_total, s_cycles_total} !== exp_totals()) begin
            n_fail++;
            $display("FAIL total_done: got %0d/%0d want %h",
                     cycles_total, s_cycles_total, exp_totals());
        end
        cmd_valid = 1'b1;
        cmd_op    = OP_RUN_FREE;
        core_stop = 1'($urandom_range(0, 1));
        tick();
        cmd_valid = 1'b0;
        core_stop = 1'($urandom_range(0, 1));
        last_reason = reason;

        n_tests++;
        if ({core_en, busy, done, cmd_err, cmd_ready} !== 5'b00001 ||
            {s_core_en, s_busy, s_done, s_cmd_err, s_cmd_ready} !== 5'b00001 ||
            {stop_reason, s_stop_reason} !== {reason, reason}) begin
            n_fail++;
            $display("FAIL idle_after_done: got %b/%b sr %0d want 00001 sr %0d",
                     {core_en, busy, done, cmd_err, cmd_ready},
                     {s_core_en, s_busy, s_done, s_cmd_err, s_cmd_ready}, stop_reason, reason);
        end
        core_stop = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        exp_total = 0;
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if ({core_en, busy, done, cmd_err, cmd_ready, stop_reason} !== 7'b0000100 ||
                cycles_left !== '0 || {cycles_total, s_cycles_total} !== '0) begin
                n_fail++;
                $display("FAIL reset_idle cyc%0d: got %b left %0d total %0d want 0000100 0 0", i,
                         {core_en, busy, done, cmd_err, cmd_ready, stop_reason},
                         cycles_left, cycles_total);
            end
            tick();
        end
    endtask

    task automatic test_run_n();
        do_run(OP_RUN_N, 3, 0, 0, 0);
        do_run(OP_RUN_N, 0, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++) do_run(OP_STEP, 0, 0, 0, 0);
    endtask

    task automatic test_free_halt();
        do_run(OP_RUN_FREE, 0, 0, 10, 0);
        do_run(OP_RUN_FREE, 0, 6, 6, 0);
    endtask

    task automatic test_core_stop();
        do_run(OP_RUN_N, 100, 5, 0, 0);
        do_run(OP_RUN_N, 8, 0, 0, 3);
        do_run(OP_RUN_FREE, 0, 4, 0, 2);
    endtask

    task automatic test_halt_idle();
        cmd_valid = 1'b1;
        cmd_op    = OP_HALT;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if ({core_en, busy, done, cmd_err, cmd_ready} !== 5'b00001 ||
                stop_reason !== last_reason) begin
                n_fail++;
                $display("FAIL halt_in_idle cyc%0d: got %b sr %0d want 00001 sr %0d", i,
                         {core_en, busy, done, cmd_err, cmd_ready}, stop_reason, last_reason);
            end
            tick();
        end
    endtask

    task automatic test_saturate();
        do_run(OP_RUN_N, 20, 0, 0, 0);
    endtask

    task automatic test_random();
        logic [1:0] op;
        int count, stop_at, halt_at;
        for (int k = 0; k < 25; k++) begin
            op      = 2'($urandom_range(0, 2));
            count   = $urandom_range(0, 12);
            stop_at = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 12) : 0;
            halt_at = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 12) : 0;
            if (op == OP_RUN_FREE && stop_at == 0 && halt_at == 0)
                halt_at = $urandom_range(1, 12);
            if (op == OP_RUN_N && count == 0) begin
                stop_at = 0;
                halt_at = 0;
            end
            do_run(op, count, stop_at, halt_at, $urandom_range(0, 12));
        end
    endtask

    task automatic test_reset_mid_run();
        do_run(OP_RUN_FREE, 0, 0, 3, 0);
        cmd_valid = 1'b1;
        cmd_op    = OP_RUN_N;
        cmd_count = CNT_W'(10);
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        exp_total = 0;
        n_tests++;
        if ({core_en, busy, done, cmd_err, cmd_ready, stop_reason} !== 7'b0000100 ||
            {s_core_en, s_busy, s_done} !== 3'b000 || cycles_left !== '0 ||
            {cycles_total, s_cycles_total} !== exp_totals()) begin
            n_fail++;
            $display("FAIL reset_mid_run: got %b left %0d total %0d/%0d want 0000100 0 0",
                     {core_en, busy, done, cmd_err, cmd_ready, stop_reason},
                     cycles_left, cycles_total, s_cycles_total);
        end
        rst_n = 1'b1;
        tick();
        n_tests++;
        if ({core_en, busy, done, cmd_ready} !== 4'b0001) begin
            n_fail++;
            $display("FAIL after_reset_release: got %b want 0001",
                     {core_en, busy, done, cmd_ready});
        end
        do_run(OP_STEP, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_run_n();
        test_back_to_back();
        test_free_halt();
        test_core_stop();
        test_halt_idle();
        test_saturate();
        test_random();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
